// File: rtl/router_register.sv
// Router datapath register stage: header latch, FIFO write byte, full-hold buffer,
// byte-wise XOR parity accumulation and parity error flag.
module router_register #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pkt_valid,
    input  logic [DW-1:0] data_in,
    input  logic          fifo_full,
    input  logic          detect_add,
    input  logic          lfd_state,
    input  logic          ld_state,
    input  logic          laf_state,
    input  logic          full_state,
    input  logic          rst_int_reg,
    output logic [DW-1:0] dout,
    output logic          parity_done,
    output logic          low_pkt_valid,
    output logic          err
);

    logic [DW-1:0] hdr;
    logic [DW-1:0] hold;
    logic          hold_is_parity;
    logic [DW-1:0] int_par;
    logic [DW-1:0] pkt_par;
    logic          parity_done_q;

    logic hdr_load;
    logic byte_load;
    logic byte_stall;
    logic par_first;

    assign hdr_load   = detect_add & pkt_valid;
    // full_state freezes everything; the byte arriving as the FIFO fills is parked in hold.
    assign byte_load  = ld_state & !fifo_full & !full_state;
    assign byte_stall = ld_state &  fifo_full & !full_state;
    assign par_first  = parity_done & !parity_done_q;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr            <= '0;
            hold           <= '0;
            hold_is_parity <= 1'b0;
            dout           <= '0;
        end else begin
            if (hdr_load)
                hdr <= data_in;

            if (lfd_state)
                dout <= hdr;
            else if (byte_load)
                dout <= data_in;
            else if (laf_state)
                dout <= hold;

            if (byte_stall) begin
                hold           <= data_in;
                hold_is_parity <= !pkt_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            int_par     <= '0;
            pkt_par     <= '0;
            parity_done <= 1'b0;
        end else if (hdr_load) begin
            int_par     <= '0;
            pkt_par     <= '0;
            parity_done <= 1'b0;
        end else if (lfd_state) begin
            int_par <= int_par ^ hdr;
        end else if (byte_load) begin
            if (pkt_valid) begin
                int_par <= int_par ^ data_in;
            end else begin
                pkt_par     <= data_in;
                parity_done <= 1'b1;
            end
        end else if (laf_state) begin
            if (!hold_is_parity) begin
                int_par <= int_par ^ hold;
            end else if (!parity_done) begin
                pkt_par     <= hold;
                parity_done <= 1'b1;
            end
        end
    end

    // err compares once, on the first cycle the received parity is available, then holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_done_q <= 1'b0;
            err           <= 1'b0;
        end else begin
            parity_done_q <= parity_done;
            if (hdr_load)
                err <= 1'b0;
            else if (par_first)
                err <= (int_par != pkt_par);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            low_pkt_valid <= 1'b0;
        else if (ld_state && !pkt_valid)
            low_pkt_valid <= 1'b1;
        else if (rst_int_reg)
            low_pkt_valid <= 1'b0;
    end

endmodule

// File: tb/tb_router_register.sv
// Self-checking bench for router_register: directed packets plus randomized packets with
// random FIFO-full stalls, checked each cycle against a packet-level model.
module tb_router_register;

    localparam int OP_IDLE = 0;
    localparam int OP_HDR  = 1;
    localparam int OP_LFD  = 2;
    localparam int OP_LD   = 3;
    localparam int OP_FULL = 4;
    localparam int OP_LAF  = 5;
    localparam int OP_CHK  = 6;
    localparam int OP_RST  = 7;

    logic       clk;
    logic       reset;
    logic       pkt_valid;
    logic [7:0] data_in;
    logic       fifo_full;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [7:0] dout;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;

    int n_checks = 0;
    int n_err    = 0;
    logic chk_en = 1'b0;

    // Packet-level model: bytes delivered to the FIFO so far, the received parity byte,
    // and the byte the source sent while the FIFO was full.
    logic [7:0] pkt_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] m_hdr, m_dout, rx_par, held_byte;
    logic       held_par;
    logic       m_pd, m_lpv, m_err, pd_rose;

    router_register #(.DW(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .fifo_full     (fifo_full),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .rst_int_reg   (rst_int_reg),
        .dout          (dout),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .err           (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] xor_all();
        logic [7:0] x;
        x = 8'h00;
        foreach (pkt_q[i]) x ^= pkt_q[i];
        return x;
    endfunction

    task automatic model_update(input int op, input logic [7:0] d, input logic pv, input logic full);
        // err resolves on the edge after the parity byte is captured, from the packet so far
        if (pd_rose) m_err = (xor_all() != rx_par);
        pd_rose = 1'b0;
        case (op)
            OP_RST: begin
                m_hdr = 8'h00; m_dout = 8'h00; rx_par = 8'h00;
                held_byte = 8'h00; held_par = 1'b0;
                m_pd = 1'b0; m_lpv = 1'b0; m_err = 1'b0;
                pkt_q.delete();
            end
            OP_HDR: if (pv) begin
                m_hdr = d; m_pd = 1'b0; m_err = 1'b0;
                pkt_q.delete();
            end
            OP_LFD: begin
                m_dout = m_hdr;
                pkt_q.push_back(m_hdr);
            end
            OP_LD: begin
                if (!pv) m_lpv = 1'b1;
                if (full) begin
                    held_byte = d;
                    held_par  = !pv;
                end else begin
                    m_dout = d;
                    if (pv) pkt_q.push_back(d);
                    else begin
                        rx_par = d;
                        if (!m_pd) pd_rose = 1'b1;
                        m_pd = 1'b1;
                    end
                end
            end
            OP_LAF: begin
                m_dout = held_byte;
                if (!held_par) pkt_q.push_back(held_byte);
                else if (!m_pd) begin
                    rx_par  = held_byte;
                    m_pd    = 1'b1;
                    pd_rose = 1'b1;
                end
            end
            OP_CHK: m_lpv = 1'b0;
            default: ;
        endcase
    endtask

    // One clock cycle: drive at negedge, update model after posedge, return at next negedge.
    task automatic step(input int op, input logic [7:0] d, input logic pv, input logic full);
        reset = 1'b0; detect_add = 1'b0; lfd_state = 1'b0; ld_state = 1'b0;
        laf_state = 1'b0; full_state = 1'b0; rst_int_reg = 1'b0;
        data_in = d; pkt_valid = pv; fifo_full = full;
        case (op)
            OP_HDR:  detect_add  = 1'b1;
            OP_LFD:  lfd_state   = 1'b1;
            OP_LD:   ld_state    = 1'b1;
            OP_FULL: full_state  = 1'b1;
            OP_LAF:  laf_state   = 1'b1;
            OP_CHK:  rst_int_reg = 1'b1;
            OP_RST:  reset       = 1'b1;
            default: ;
        endcase
        @(posedge clk);
        #1;
        model_update(op, d, pv, full);
        chk_en = 1'b1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dout", 32'(dout), 32'(m_dout));
            check("parity_done", 32'(parity_done), 32'(m_pd));
            check("low_pkt_valid", 32'(low_pkt_valid), 32'(m_lpv));
            check("err", 32'(err), 32'(m_err));
        end
    end

    always @(negedge clk) begin
        assert ($onehot0({detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg}))
        else $error("state strobes not one-hot");
    end

    // Random packet from tx_q; pfull is the percent chance each byte meets a full FIFO.
    task automatic send_packet(input logic [7:0] hdr, input logic [7:0] par, input int pfull);
        logic [7:0] b;
        logic       pv;
        step(OP_HDR, hdr, 1'b1, 1'b0);
        step(OP_LFD, 8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i <= tx_q.size(); i++) begin
            pv = (i < tx_q.size());
            b  = pv ? tx_q[i] : par;
            if ($urandom_range(0, 99) < pfull) begin
                step(OP_LD, b, pv, 1'b1);
                repeat ($urandom_range(0, 3)) step(OP_FULL, 8'($urandom), pv, 1'b1);
                step(OP_LAF, 8'($urandom), pv, 1'b0);
            end else begin
                step(OP_LD, b, pv, 1'b0);
            end
        end
        step(OP_IDLE, 8'($urandom), 1'b0, 1'b0);
        step(OP_CHK, 8'($urandom), 1'b0, 1'b0);
        repeat ($urandom_range(0, 2)) step(OP_IDLE, 8'($urandom), 1'b0, 1'b0);
    endtask

    initial begin
        int         len;
        logic [7:0] hb;
        logic [7:0] par;

        step(OP_RST, 8'h00, 1'b0, 1'b0);
        step(OP_RST, 8'h00, 1'b0, 1'b0);
        check("reset_dout", 32'(dout), 32'h0);
        check("reset_err", 32'(err), 32'h0);

        // Normal packet: 0D, 11, 22, 33, parity 0D
        step(OP_HDR, 8'h0D, 1'b1, 1'b0);
        step(OP_LFD, 8'h11, 1'b1, 1'b0);
        check("t1_dout_hdr", 32'(dout), 32'h0D);
        step(OP_LD, 8'h11, 1'b1, 1'b0);
        check("t1_dout_11", 32'(dout), 32'h11);
        step(OP_LD, 8'h22, 1'b1, 1'b0);
        step(OP_LD, 8'h33, 1'b1, 1'b0);
        check("t1_dout_33", 32'(dout), 32'h33);
        step(OP_LD, 8'h0D, 1'b0, 1'b0);
        check("t1_dout_par", 32'(dout), 32'h0D);
        check("t1_parity_done", 32'(parity_done), 32'h1);
        step(OP_IDLE, 8'h00, 1'b0, 1'b0);
        check("t1_err", 32'(err), 32'h0);
        check("t1_lpv", 32'(low_pkt_valid), 32'h1);
        step(OP_CHK, 8'h00, 1'b0, 1'b0);
        check("t1_lpv_clr", 32'(low_pkt_valid), 32'h0);

        // Bad parity 0E
        step(OP_HDR, 8'h0D, 1'b1, 1'b0);
        check("t2_pd_clr", 32'(parity_done), 32'h0);
        step(OP_LFD, 8'h00, 1'b1, 1'b0);
        step(OP_LD, 8'h11, 1'b1, 1'b0);
        step(OP_LD, 8'h22, 1'b1, 1'b0);
        step(OP_LD, 8'h33, 1'b1, 1'b0);
        step(OP_LD, 8'h0E, 1'b0, 1'b0);
        check("t2_err_not_yet", 32'(err), 32'h0);
        step(OP_IDLE, 8'h00, 1'b0, 1'b0);
        check("t2_err_set", 32'(err), 32'h1);
        step(OP_CHK, 8'h00, 1'b0, 1'b0);
        check("t2_err_holds", 32'(err), 32'h1);

        // Next header clears err; FIFO full while 0x22 arrives
        step(OP_HDR, 8'h0D, 1'b1, 1'b0);
        check("t6_err_clr", 32'(err), 32'h0);
        step(OP_LFD, 8'h00, 1'b1, 1'b0);
        step(OP_LD, 8'h11, 1'b1, 1'b0);
        step(OP_LD, 8'h22, 1'b1, 1'b1);
        check("t3_dout_hold", 32'(dout), 32'h11);
        repeat (3) step(OP_FULL, 8'h5A, 1'b1, 1'b1);
        check("t3_dout_frozen", 32'(dout), 32'h11);
        step(OP_LAF, 8'h00, 1'b1, 1'b0);
        check("t3_dout_laf", 32'(dout), 32'h22);
        step(OP_LD, 8'h33, 1'b1, 1'b0);
        step(OP_LD, 8'h0D, 1'b0, 1'b0);
        step(OP_IDLE, 8'h00, 1'b0, 1'b0);
        check("t3_err", 32'(err), 32'h0);
        step(OP_CHK, 8'h00, 1'b0, 1'b0);

        // FIFO full on the parity byte
        step(OP_HDR, 8'h0D, 1'b1, 1'b0);
        step(OP_LFD, 8'h00, 1'b1, 1'b0);
        step(OP_LD, 8'h11, 1'b1, 1'b0);
        step(OP_LD, 8'h22, 1'b1, 1'b0);
        step(OP_LD, 8'h33, 1'b1, 1'b0);
        step(OP_LD, 8'h0D, 1'b0, 1'b1);
        check("t4_pd_wait", 32'(parity_done), 32'h0);
        repeat (2) step(OP_FULL, 8'hFF, 1'b0, 1'b1);
        check("t4_pd_still", 32'(parity_done), 32'h0);
        step(OP_LAF, 8'h00, 1'b0, 1'b0);
        check("t4_pd_laf", 32'(parity_done), 32'h1);
        check("t4_dout_laf", 32'(dout), 32'h0D);
        step(OP_IDLE, 8'h00, 1'b0, 1'b0);
        check("t4_err", 32'(err), 32'h0);
        step(OP_CHK, 8'h00, 1'b0, 1'b0);

        // Reset mid-packet, then a clean short packet
        step(OP_HDR, 8'h0D, 1'b1, 1'b0);
        step(OP_LFD, 8'h00, 1'b1, 1'b0);
        step(OP_LD, 8'h11, 1'b1, 1'b0);
        step(OP_RST, 8'h00, 1'b1, 1'b0);
        check("t5_dout_rst", 32'(dout), 32'h0);
        step(OP_HDR, 8'h05, 1'b1, 1'b0);
        step(OP_LFD, 8'h00, 1'b1, 1'b0);
        step(OP_LD, 8'hAA, 1'b1, 1'b0);
        step(OP_LD, 8'hAF, 1'b0, 1'b0);
        step(OP_IDLE, 8'h00, 1'b0, 1'b0);
        check("t5_err", 32'(err), 32'h0);
        step(OP_CHK, 8'h00, 1'b0, 1'b0);

        // Randomized packets, some with corrupted parity and random stalls
        for (int p = 0; p < 60; p++) begin
            len = $urandom_range(1, 8);
            hb  = {6'(len), 2'($urandom_range(0, 2))};
            tx_q.delete();
            par = hb;
            for (int i = 0; i < len; i++) begin
                tx_q.push_back(8'($urandom));
                par ^= tx_q[i];
            end
            if ($urandom_range(0, 1) == 1) par ^= 8'(1 << $urandom_range(0, 7));
            send_packet(hb, par, 25);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
